// File: rtl/sdp_clear_ram.sv
// Simple dual-port RAM with zero-fill on reset/clear, byte-lane writes,
// selectable collision behaviour and optional output register.
module sdp_clear_ram #(
    parameter int WIDTH      = 64,
    parameter int DEPTH      = 512,
    parameter int ADDR_WIDTH = 9,
    parameter int BYTE_WIDTH = 8,
    parameter int OUT_REG    = 0,
    parameter int WR_FIRST   = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    output logic                          busy,
    input  logic                          wr_en,
    input  logic [WIDTH/BYTE_WIDTH-1:0]   wr_be,
    input  logic [ADDR_WIDTH-1:0]         addr_a,
    input  logic [WIDTH-1:0]              d_in,
    input  logic                          rd_en,
    input  logic [ADDR_WIDTH-1:0]         addr_b,
    output logic [WIDTH-1:0]              d_out,
    output logic                          rd_valid
);

    localparam int NBE = WIDTH / BYTE_WIDTH;
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  ready;
    logic                  rd_go;
    logic                  wr_go;
    logic [WIDTH-1:0]      merged;
    logic [WIDTH-1:0]      rd_word;
    logic                  s1_valid;
    logic [WIDTH-1:0]      s1_data;

    assign ready = (state == ST_READY);
    assign busy  = ~ready;
    assign rd_go = ready & rd_en;
    assign wr_go = ready & wr_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end else begin
            unique case (state)
                ST_CLEAR: begin
                    if (cnt == LAST) begin
                        state <= ST_READY;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_READY: begin
                    if (clear) begin
                        state <= ST_CLEAR;
                        cnt   <= '0;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

    // Post-write word: enabled lanes from d_in, the rest from the old word
    always_comb begin
        merged = mem[addr_a];
        for (int i = 0; i < NBE; i++) begin
            if (wr_be[i]) begin
                merged[i*BYTE_WIDTH +: BYTE_WIDTH] = d_in[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    always_comb begin
        rd_word = mem[addr_b];
        if (WR_FIRST != 0 && wr_go && addr_a == addr_b) begin
            rd_word = merged;
        end
    end

    // Storage itself has no reset; the fill is gated so rst_n never writes it
    always_ff @(posedge clk) begin
        if (!ready && rst_n) begin
            mem[cnt] <= '0;
        end else if (wr_go) begin
            mem[addr_a] <= merged;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_go;
            if (rd_go) begin
                s1_data <= rd_word;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic             s2_valid;
            logic [WIDTH-1:0] s2_data;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign rd_valid = s2_valid;
            assign d_out    = s2_data;
        end else begin : g_noreg
            assign rd_valid = s1_valid;
            assign d_out    = s1_data;
        end
    endgenerate

endmodule

// File: tb/tb_sdp_clear_ram.sv
// Randomised bench: two RAM builds (OUT_REG=0/read-first, OUT_REG=1/write-first)
// driven in parallel and checked every cycle against an array-based model.
module tb_sdp_clear_ram;

    localparam int W   = 64;
    localparam int D   = 512;
    localparam int AW  = 9;
    localparam int NBE = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          wr_en;
    logic [NBE-1:0] wr_be;
    logic [AW-1:0] addr_a;
    logic [W-1:0]  d_in;
    logic          rd_en;
    logic [AW-1:0] addr_b;
    logic          busy0, busy1;
    logic [W-1:0]  d_out0, d_out1;
    logic          rd_valid0, rd_valid1;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] ref_mem [D];
    int           fill_left;
    logic         e0_v, p_v, e1_v;
    logic [W-1:0] e0_d, p_d, e1_d;

    always #5 clk = ~clk;

    sdp_clear_ram #(
        .WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .BYTE_WIDTH(8),
        .OUT_REG(0), .WR_FIRST(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy0),
        .wr_en(wr_en), .wr_be(wr_be), .addr_a(addr_a), .d_in(d_in),
        .rd_en(rd_en), .addr_b(addr_b), .d_out(d_out0), .rd_valid(rd_valid0)
    );

    sdp_clear_ram #(
        .WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .BYTE_WIDTH(8),
        .OUT_REG(1), .WR_FIRST(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy1),
        .wr_en(wr_en), .wr_be(wr_be), .addr_a(addr_a), .d_in(d_in),
        .rd_en(rd_en), .addr_b(addr_b), .d_out(d_out1), .rd_valid(rd_valid1)
    );

    task automatic check(input string tag, input logic [W-1:0] got,
                         input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("busy0", W'(busy0), W'(fill_left > 0));
        check("busy1", W'(busy1), W'(fill_left > 0));
        check("rd_valid0", W'(rd_valid0), W'(e0_v));
        check("rd_valid1", W'(rd_valid1), W'(e1_v));
        check("d_out0", d_out0, e0_d);
        check("d_out1", d_out1, e1_d);
    endtask

    task automatic idle_inputs();
        clear = 0; wr_en = 0; rd_en = 0; wr_be = '0;
        addr_a = '0; addr_b = '0; d_in = '0;
    endtask

    // One clock edge: update the model from the sampled inputs, then compare
    task automatic step();
        logic         acc, wacc;
        logic [W-1:0] old, mrg, wf;
        @(posedge clk);
        acc  = (fill_left == 0) && rd_en;
        wacc = (fill_left == 0) && wr_en;
        old  = ref_mem[addr_b];
        mrg  = ref_mem[addr_a];
        for (int i = 0; i < NBE; i++)
            if (wr_be[i]) mrg[i*8 +: 8] = d_in[i*8 +: 8];
        wf = (wacc && addr_a == addr_b) ? mrg : old;
        e1_v = p_v;
        if (p_v) e1_d = p_d;
        p_v = acc;
        if (acc) p_d = wf;
        e0_v = acc;
        if (acc) e0_d = old;
        if (fill_left > 0) begin
            ref_mem[D - fill_left] = '0;
            fill_left--;
        end else begin
            if (wacc) ref_mem[addr_a] = mrg;
            if (clear) fill_left = D;
        end
        #1 check_all();
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        fill_left = D;
        e0_v = 0; p_v = 0; e1_v = 0;
        e0_d = '0; p_d = '0; e1_d = '0;
        #1 check_all();
        @(posedge clk);
        #4 rst_n = 1'b1;
    endtask

    task automatic rd(input int a);
        idle_inputs();
        rd_en = 1; addr_b = AW'(a);
        step();
    endtask

    task automatic wr(input int a, input logic [W-1:0] d, input logic [NBE-1:0] be);
        idle_inputs();
        wr_en = 1; addr_a = AW'(a); d_in = d; wr_be = be;
        step();
    endtask

    task automatic idle(input int n);
        idle_inputs();
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rand_cycle(input int arange);
        clear  = 0;
        wr_en  = 1'($urandom);
        rd_en  = 1'($urandom);
        wr_be  = NBE'($urandom);
        addr_a = AW'($urandom_range(arange - 1, 0));
        addr_b = ($urandom_range(3, 0) == 0) ? addr_a : AW'($urandom_range(arange - 1, 0));
        d_in   = {$urandom, $urandom};
        step();
    endtask

    initial begin
        for (int i = 0; i < D; i++) ref_mem[i] = '0;
        idle_inputs();
        rst_n = 1'b1;
        do_reset();
        idle(D + 2);

        rd(0); rd(255); rd(511); idle(2);

        wr(5, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        wr(5, 64'h1122_3344_5566_7788, 8'h0F);
        rd(5);
        check("be_direct", d_out0, 64'hFFFF_FFFF_5566_7788);
        idle(2);

        wr(9, 64'hAAAA, 8'hFF);
        idle_inputs();
        wr_en = 1; addr_a = 9; d_in = 64'h5555; wr_be = 8'hFF;
        rd_en = 1; addr_b = 9;
        step();
        check("coll_rf", d_out0, 64'hAAAA);
        idle(1);
        check("coll_wf", d_out1, 64'h5555);
        rd(9); idle(2);

        for (int i = 0; i < 16; i++) rd(i);
        idle(3);

        for (int i = 0; i < 600; i++) rand_cycle(($urandom_range(1, 0) != 0) ? 16 : D);
        idle(2);

        for (int i = 0; i < D; i++) wr(i, {32'(i), ~32'(i)}, 8'hFF);
        idle_inputs();
        clear = 1; wr_en = 1; wr_be = 8'hFF; addr_a = 3; d_in = 64'h1234;
        rd_en = 1; addr_b = 3;
        step();
        for (int i = 0; i < D; i++) rand_cycle(D);
        idle(1);
        for (int i = 0; i < D; i++) rd(i);
        idle(3);

        wr(7, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF);
        rd(7);
        do_reset();
        idle(D + 3);

        idle_inputs();
        clear = 1;
        step();
        idle(100);
        do_reset();
        idle(D + 2);
        for (int i = 0; i < 200; i++) rand_cycle(32);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
